// File: rtl/seg7_scan_decoder.sv
// Rebuilds hex digits from a multiplexed active-low 7-segment bus with per-digit debouncing.
// Captures land STABLE_CYCLES+1 clocks after the pins settle; passive monitor with no backpressure.
module seg7_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [N_DIGITS-1:0]     an_in,
  output logic [4*N_DIGITS-1:0]   digits_out,
  output logic [N_DIGITS-1:0]     digit_valid,
  output logic [N_DIGITS-1:0]     digit_err,
  output logic                    update,
  output logic                    frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0]          STABLE = 8'(STABLE_CYCLES);
  localparam logic [N_DIGITS-1:0] ONE    = N_DIGITS'(1);

  state_t              state;
  logic [7:0]          count;
  logic [6:0]          seg_q, seg_p;
  logic [N_DIGITS-1:0] an_q, an_p, seen;

  logic [N_DIGITS-1:0] sel, seen_nxt;
  logic                an_legal, same, capture;
  logic [7:0]          cnt_trk;
  logic [3:0]          nib;
  logic                code_ok, blank;

  // ~an_q is the digit select; it must be exactly one-hot for the sample to count.
  always_comb begin
    sel      = ~an_q;
    an_legal = (sel != '0) && ((sel & (sel - ONE)) == '0);
    same     = (seg_q == seg_p) && (an_q == an_p);
    seen_nxt = seen | sel;
    if (state == TRACK && same)
      cnt_trk = (count < STABLE) ? count + 8'd1 : count;
    else
      cnt_trk = 8'd1;
    capture = an_legal && !(state == HOLD && same) && (cnt_trk >= STABLE);
  end

  always_comb begin
    nib     = 4'h0;
    code_ok = 1'b1;
    blank   = 1'b0;
    case (seg_q)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      7'b0111111, 7'b1111111: begin
        code_ok = 1'b0;
        blank   = 1'b1;
      end
      default: code_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      seg_q       <= '1;
      seg_p       <= '1;
      an_q        <= '1;
      an_p        <= '1;
      seen        <= '0;
      digits_out  <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      update      <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      seg_q      <= seg_in;
      an_q       <= an_in;
      seg_p      <= seg_q;
      an_p       <= an_q;
      update     <= 1'b0;
      frame_done <= 1'b0;

      if (!an_legal) begin
        state <= IDLE;
        count <= '0;
      end else if (!(state == HOLD && same)) begin
        count <= cnt_trk;
        state <= capture ? HOLD : TRACK;
      end

      if (capture) begin
        update <= 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
          if (sel[i]) begin
            if (code_ok) begin
              digits_out[4*i +: 4] <= nib;
              digit_valid[i]       <= 1'b1;
              digit_err[i]         <= 1'b0;
            end else if (blank) begin
              digits_out[4*i +: 4] <= 4'h0;
              digit_valid[i]       <= 1'b0;
              digit_err[i]         <= 1'b0;
            end else begin
              digit_valid[i]       <= 1'b0;
              digit_err[i]         <= 1'b1;
            end
          end
        end
        // Re-capturing an already-seen digit leaves the mask unchanged.
        if (&seen_nxt) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen       <= seen_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: default 4-digit/4-cycle instance plus a 2-digit/1-cycle instance.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits_out;
  logic [3:0]  digit_valid, digit_err;
  logic        update, frame_done;

  logic [6:0]  seg1;
  logic [1:0]  an1;
  logic [7:0]  digits1;
  logic [1:0]  valid1, err1;
  logic        update1, frame_done1;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .digit_valid(digit_valid), .digit_err(digit_err),
    .update(update), .frame_done(frame_done)
  );

  seg7_scan_decoder #(.N_DIGITS(2), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .seg_in(seg1), .an_in(an1),
    .digits_out(digits1), .digit_valid(valid1), .digit_err(err1),
    .update(update1), .frame_done(frame_done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one pair for n cycles; update/frame_done must pulse only at the given step (0 = never).
  task automatic hold(input string tag, input logic [3:0] an, input logic [6:0] seg,
                      input int n, input int cap_at, input int fd_at);
    an_in  = an;
    seg_in = seg;
    for (int k = 1; k <= n; k++) begin
      step();
      chk($sformatf("%s update k%0d", tag, k), 32'(update), 32'(k == cap_at));
      chk($sformatf("%s frame_done k%0d", tag, k), 32'(frame_done), 32'(k == fd_at));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat [4];
    pat[0] = 7'b1111001;
    pat[1] = 7'b0100100;
    pat[2] = 7'b0110000;
    pat[3] = 7'b0011001;

    rst = 1'b1;
    an_in = '1;
    seg_in = '1;
    an1 = '1;
    seg1 = '1;
    step();
    step();
    chk("reset digits", 32'(digits_out), 32'h0);
    chk("reset valid", 32'(digit_valid), 32'h0);
    chk("reset err", 32'(digit_err), 32'h0);
    chk("reset update", 32'(update), 32'h0);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;

    // Single digit 3 on digit 0: capture on the 5th edge only.
    hold("first", 4'b1110, 7'b0110000, 6, 5, 0);
    chk("first digits", 32'(digits_out), 32'h0003);
    chk("first valid", 32'(digit_valid), 32'h1);
    chk("first err", 32'(digit_err), 32'h0);

    // Full scan 1,2,3,4; frame completes with the digit 3 capture.
    for (int d = 0; d < 4; d++)
      hold($sformatf("scan d%0d", d), ~(4'b0001 << d), pat[d], 8, 5, (d == 3) ? 5 : 0);
    chk("scan digits", 32'(digits_out), 32'h4321);
    chk("scan valid", 32'(digit_valid), 32'hF);
    chk("scan seen cleared", 32'(dut.seen), 32'h0);

    // Two-cycle ghost of 8 ahead of each real 7 must never be captured.
    for (int d = 0; d < 4; d++) begin
      hold($sformatf("ghost d%0d", d), ~(4'b0001 << d), 7'b0000000, 2, 0, 0);
      hold($sformatf("real d%0d", d), ~(4'b0001 << d), 7'b1111000, 8, 5, (d == 3) ? 5 : 0);
    end
    chk("ghost digits", 32'(digits_out), 32'h7777);
    chk("ghost valid", 32'(digit_valid), 32'hF);
    chk("ghost err", 32'(digit_err), 32'h0);

    hold("dash d1", 4'b1101, 7'b0111111, 8, 5, 0);
    chk("dash digits", 32'(digits_out), 32'h7707);
    chk("dash valid", 32'(digit_valid), 32'hD);
    chk("dash err", 32'(digit_err), 32'h0);
    hold("bad d1", 4'b1101, 7'b1010101, 8, 5, 0);
    chk("bad d1 digits", 32'(digits_out), 32'h7707);
    chk("bad d1 valid", 32'(digit_valid), 32'hD);
    chk("bad d1 err", 32'(digit_err), 32'h2);
    hold("bad d2", 4'b1011, 7'b1010101, 8, 5, 0);
    chk("bad d2 digits", 32'(digits_out), 32'h7707);
    chk("bad d2 valid", 32'(digit_valid), 32'h9);
    chk("bad d2 err", 32'(digit_err), 32'h6);

    hold("two low", 4'b1100, 7'b1010101, 10, 0, 0);
    chk("two low state", 32'(dut.state), 32'h0);
    hold("none low", 4'b1111, 7'b1010101, 10, 0, 0);
    chk("none low state", 32'(dut.state), 32'h0);
    chk("none low count", 32'(dut.count), 32'h0);

    // Reset lands when the count is 3, one edge before a capture would happen.
    hold("pre rst", 4'b1011, 7'b0110000, 4, 0, 0);
    chk("pre rst count", 32'(dut.count), 32'h3);
    rst = 1'b1;
    step();
    chk("mid rst digits", 32'(digits_out), 32'h0);
    chk("mid rst valid", 32'(digit_valid), 32'h0);
    chk("mid rst err", 32'(digit_err), 32'h0);
    chk("mid rst update", 32'(update), 32'h0);
    chk("mid rst state", 32'(dut.state), 32'h0);
    rst = 1'b0;
    hold("post rst", 4'b1011, 7'b0110000, 6, 5, 0);
    chk("post rst digits", 32'(digits_out), 32'h0300);
    chk("post rst valid", 32'(digit_valid), 32'h4);

    // STABLE_CYCLES=1 captures on the first legal registered sample.
    an1 = 2'b01;
    seg1 = 7'b0001000;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("s1 A update k%0d", k), 32'(update1), 32'(k == 2));
      chk($sformatf("s1 A frame_done k%0d", k), 32'(frame_done1), 32'h0);
    end
    chk("s1 A digits", 32'(digits1), 32'hA0);
    chk("s1 A valid", 32'(valid1), 32'h2);
    an1 = 2'b10;
    seg1 = 7'b0000011;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("s1 B update k%0d", k), 32'(update1), 32'(k == 2));
      chk($sformatf("s1 B frame_done k%0d", k), 32'(frame_done1), 32'(k == 2));
    end
    chk("s1 B digits", 32'(digits1), 32'hAB);
    chk("s1 B valid", 32'(valid1), 32'h3);
    chk("s1 B err", 32'(err1), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
